// File: rtl/crc_n_ctrl.sv
// Bit-serial CRC-N sequencer: accepts a message word, divides it MSB first one bit per clock, returns the remainder.
// Optional check mode (compare against a received CRC) is enabled by defining CRC_N_CHECK_EN.
module crc_n_ctrl #(
   parameter int              DW   = 8,
   parameter int              BW   = 3,
   parameter logic [BW-1:0]   POLY = 3'b011
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_mode,
   input  logic [BW-1:0] in_crc,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [BW-1:0] out_crc,
   output logic          out_err,
   output logic          busy
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // ready/valid here are pure decodes of the registered state.
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] sr_q, sr_d;
   logic [BW-1:0] rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] out_crc_q, out_crc_d;
   logic          fb;
   logic [BW-1:0] rem_nxt;
   logic          last_step;

`ifdef CRC_N_CHECK_EN
   logic          mode_q, mode_d;
   logic [BW-1:0] hcrc_q, hcrc_d;
   logic          out_err_q, out_err_d;
`else
   logic          unused_cfg;
   assign unused_cfg = ^{in_mode, in_crc};
`endif

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      out_crc_d = out_crc_q;
`ifdef CRC_N_CHECK_EN
      mode_d    = mode_q;
      hcrc_d    = hcrc_q;
      out_err_d = out_err_q;
`endif
      fb        = rem_q[BW-1] ^ sr_q[DW-1];
      rem_nxt   = {rem_q[BW-2:0], 1'b0} ^ (fb ? POLY : '0);
      last_step = (cnt_q == CW'(DW - 1));

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sr_d    = in_data;
               rem_d   = '0;
               cnt_d   = '0;
`ifdef CRC_N_CHECK_EN
               mode_d  = in_mode;
               hcrc_d  = in_crc;
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            rem_d = rem_nxt;
            sr_d  = sr_q << 1;
            if (last_step) begin
               // Result registers load with the final remainder so they stay valid after leaving DONE.
               out_crc_d = rem_nxt;
`ifdef CRC_N_CHECK_EN
               out_err_d = mode_q && (rem_nxt != hcrc_q);
`endif
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         out_crc_q <= '0;
`ifdef CRC_N_CHECK_EN
         mode_q    <= 1'b0;
         hcrc_q    <= '0;
         out_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         out_crc_q <= out_crc_d;
`ifdef CRC_N_CHECK_EN
         mode_q    <= mode_d;
         hcrc_q    <= hcrc_d;
         out_err_q <= out_err_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_crc   = out_crc_q;
`ifdef CRC_N_CHECK_EN
   assign out_err   = out_err_q;
`else
   assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_crc_n_ctrl.sv
// Self-checking bench for crc_n_ctrl: directed scenarios plus randomized requests against a long-division model.
// Check-mode expectations follow CRC_N_CHECK_EN.
module tb_crc_n_ctrl;
   localparam int            DW   = 8;
   localparam int            BW   = 3;
   localparam logic [BW-1:0] POLY = 3'b011;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_mode;
   logic [BW-1:0] in_crc;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] out_crc;
   logic          out_err;
   logic          busy;

   int checks   = 0;
   int failures = 0;
   logic [BW-1:0] exp_q[$];

   crc_n_ctrl #(.DW(DW), .BW(BW), .POLY(POLY)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_mode(in_mode), .in_crc(in_crc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_crc(out_crc), .out_err(out_err), .busy(busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_crc = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- reference model ----------------
   // Remainder of M(x)*x^BW divided by the full generator {1,POLY}, by textbook long division.
   function automatic logic [BW-1:0] model_crc(input logic [DW-1:0] d);
      logic [DW+BW-1:0] v;
      logic [BW:0]      g;
      v = {d, {BW{1'b0}}};
      g = {1'b1, POLY};
      for (int i = DW + BW - 1; i >= BW; i--)
         if (v[i]) v[i -: BW+1] = v[i -: BW+1] ^ g;
      return v[BW-1:0];
   endfunction

   function automatic logic model_err(input logic m, input logic [BW-1:0] c, input logic [BW-1:0] r);
`ifdef CRC_N_CHECK_EN
      return m && (c != r);
`else
      return 1'b0;
`endif
   endfunction

   // ---------------- drivers ----------------
   task automatic accept(input logic [DW-1:0] d, input logic m, input logic [BW-1:0] c, input bit keep);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_mode = m; in_crc = c;
      @(posedge clk);
      #1;
      if (!keep) in_valid = 1'b0;
   endtask

   // Returns edges from the accept edge until out_valid is seen, or -1 on timeout.
   task automatic wait_done(output int n, input bit noise);
      bit done;
      n = 0; done = 1'b0;
      while (!done && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (out_valid) done = 1'b1;
         else if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DW'($urandom);
         end
      end
      if (noise) in_valid = 1'b0;
      if (!done) n = -1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_crc !== 3'b000) begin failures++; $display("FAIL reset_out_crc got=%b exp=000", out_crc); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_generate();
      int n;
      logic [BW-1:0] e;
      e = model_crc(8'hD3);
      out_ready = 1'b1;
      accept(8'hD3, 1'b0, '0, 1'b0);
      wait_done(n, 1'b0);
      checks++; if (n !== DW) begin failures++; $display("FAIL gen_latency got=%0d exp=%0d", n, DW); end
      checks++; if (out_crc !== e || out_crc !== 3'b011) begin failures++; $display("FAIL gen_crc got=%b exp=%b", out_crc, e); end
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL gen_done_flags in_ready=%b busy=%b exp 0/1", in_ready, busy); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL gen_back_idle in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
      checks++; if (out_crc !== e) begin failures++; $display("FAIL gen_hold_crc got=%b exp=%b", out_crc, e); end
      // Accept again at the earliest edge: 10 edges after the first accept.
      in_valid = 1'b1; in_data = 8'h80;
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_done(n, 1'b0);
      checks++; if (n !== DW) begin failures++; $display("FAIL gen_spacing_latency got=%0d exp=%0d", n, DW); end
      checks++; if (out_crc !== model_crc(8'h80)) begin failures++; $display("FAIL gen_spacing_crc got=%b exp=%b", out_crc, model_crc(8'h80)); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n;
      out_ready = 1'b1;
      accept(8'h80, 1'b0, '0, 1'b1);
      in_data = 8'h00;
      wait_done(n, 1'b0);
      checks++; if (n !== DW) begin failures++; $display("FAIL b2b_latency1 got=%0d exp=%0d", n, DW); end
      checks++; if (out_crc !== 3'b011) begin failures++; $display("FAIL b2b_crc1 got=%b exp=011", out_crc); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_gap out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_done(n, 1'b0);
      checks++; if (n !== DW) begin failures++; $display("FAIL b2b_latency2 got=%0d exp=%0d", n, DW); end
      checks++; if (out_crc !== 3'b000) begin failures++; $display("FAIL b2b_crc2 got=%b exp=000", out_crc); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int n;
      out_ready = 1'b0;
      accept(8'hD3, 1'b0, '0, 1'b0);
      wait_done(n, 1'b0);
      checks++; if (n !== DW) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", n, DW); end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'hFF;
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_crc !== 3'b011 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d out_valid=%b out_crc=%b in_ready=%b exp 1/011/0", i, out_valid, out_crc, in_ready);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
   endtask

   task automatic test_check_mode();
      int n;
      logic e;
      out_ready = 1'b1;
      accept(8'hD3, 1'b1, 3'b011, 1'b0);
      wait_done(n, 1'b0);
      checks++; if (out_err !== 1'b0 || out_crc !== 3'b011) begin failures++; $display("FAIL chk_match err=%b crc=%b exp 0/011", out_err, out_crc); end
      @(negedge clk);
      accept(8'hD3, 1'b1, 3'b010, 1'b0);
      wait_done(n, 1'b0);
      e = model_err(1'b1, 3'b010, model_crc(8'hD3));
      checks++; if (out_err !== e) begin failures++; $display("FAIL chk_mismatch err=%b exp=%b", out_err, e); end
      @(negedge clk);
      checks++; if (out_err !== e || out_valid !== 1'b0) begin failures++; $display("FAIL chk_hold err=%b out_valid=%b exp %b/0", out_err, out_valid, e); end
   endtask

   task automatic test_reset_mid();
      int n;
      out_ready = 1'b1;
      accept(8'hD3, 1'b1, 3'b010, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_crc !== 3'b000 || out_err !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid in_ready=%b out_valid=%b busy=%b out_crc=%b out_err=%b exp 1/0/0/000/0",
                  in_ready, out_valid, busy, out_crc, out_err);
      end
      rst = 1'b0;
      accept(8'h80, 1'b0, '0, 1'b0);
      wait_done(n, 1'b0);
      checks++; if (n !== DW || out_crc !== 3'b011) begin failures++; $display("FAIL rst_mid_after lat=%0d crc=%b exp %0d/011", n, out_crc, DW); end
      @(negedge clk);
   endtask

   task automatic test_random();
      int n;
      int hold;
      logic [DW-1:0] d;
      logic          m;
      logic [BW-1:0] c;
      logic [BW-1:0] e;
      logic          ee;
      for (int t = 0; t < 24; t++) begin
         d = DW'($urandom);
         m = 1'($urandom_range(0, 1));
         c = BW'($urandom_range(0, (1 << BW) - 1));
         exp_q.push_back(model_crc(d));
         out_ready = 1'b0;
         accept(d, m, c, 1'b0);
         wait_done(n, 1'b1);
         e  = exp_q.pop_front();
         ee = model_err(m, c, e);
         checks++; if (n !== DW) begin failures++; $display("FAIL rnd_latency t=%0d got=%0d exp=%0d", t, n, DW); end
         checks++; if (out_crc !== e) begin failures++; $display("FAIL rnd_crc t=%0d data=%h got=%b exp=%b", t, d, out_crc, e); end
         checks++; if (out_err !== ee) begin failures++; $display("FAIL rnd_err t=%0d got=%b exp=%b", t, out_err, ee); end
         hold = $urandom_range(0, 3);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_crc !== e) begin failures++; $display("FAIL rnd_hold t=%0d out_valid=%b crc=%b exp 1/%b", t, out_valid, out_crc, e); end
         end
         out_ready = 1'b1;
         @(negedge clk);
         checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rnd_release t=%0d out_valid=%b in_ready=%b", t, out_valid, in_ready); end
      end
      out_ready = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_crc = '0; out_ready = 1'b0;
      test_reset();
      test_generate();
      test_back_to_back();
      test_backpressure();
      test_check_mode();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/crc_n_ctrl.md
# crc_n_ctrl

Sequencing controller for the CRC-N datapath. It accepts a DW-bit message word over a valid/ready handshake and runs bit-serial polynomial long division, MSB first, one bit per clock. Each step is the conditional-XOR operation of the BW-bit CRC unit, with the select driven by the feedback bit. It returns the BW-bit remainder over a second valid/ready handshake and, when configured, flags a mismatch against a received CRC. It sits between the frame packer/unpacker and the CRC unit and owns all cycle sequencing of that unit.

## Interface
- `DW`, 8, message width in bits (≥ 2).
- `BW`, 3, CRC width in bits (≥ 2).
- `POLY`, 3'b011, generator polynomial without its implicit leading 1 (default x^3+x+1, i.e. 1011).

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  controller can accept a request.
- `in_data`  in  DW  message word; bit DW-1 is processed first.
- `in_mode`  in  1  0 = generate, 1 = check (see Configuration).
- `in_crc`  in  BW  received CRC to compare in check mode.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_crc`  out  BW  computed remainder.
- `out_err`  out  1  check mode: out_crc ≠ captured in_crc.
- `busy`  out  1  high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: capture `in_data` into shift register `sr`, and `in_mode`/`in_crc` into holding registers.
  - Clear `rem` to 0 and bit counter `cnt` to 0; go to SHIFT.
- SHIFT, per cycle:
  - Feedback `fb = rem[BW-1] ^ sr[DW-1]`.
  - `rem <= {rem[BW-2:0],1'b0} ^ (fb ? POLY : 0)`.
  - `sr <= sr << 1`; `cnt <= cnt + 1`.
  - When `cnt == DW-1`, go to DONE after this update.
  - `cnt` is `$clog2(DW)` bits wide and never wraps within a request.
- DONE:
  - `out_valid` = 1.
  - `out_crc` = `rem`, stable until accepted.
  - `out_err` = held mode ? (`rem != held crc`) : 0.
  - On `out_ready`: go to IDLE.
- `in_valid` outside IDLE is ignored; there is no queuing. `in_data` changes outside the accept cycle have no effect.
- `out_ready` outside DONE is ignored.
- Arithmetic is GF(2) only: no carries and no width growth. `rem` is exactly BW bits and the initial value is 0.

## Timing
- Reset (synchronous): state IDLE.
  - `in_ready` = 1; `out_valid` = 0; `busy` = 0.
  - `out_crc` = 0; `out_err` = 0.
  - Internal `rem`, `sr`, `cnt` and holding registers = 0.
- Reset asserted mid-SHIFT or in DONE:
  - Next edge forces the reset values; any pending result is discarded.
  - `rst` has priority over all handshakes in the same cycle.
- Latency: accept at edge k gives `out_valid` high after edge k+DW, i.e. DW cycles in SHIFT.
- Throughput: with `out_ready` tied high, DONE lasts 1 cycle. Minimum request spacing is DW+2 cycles (accept, DW shifts, DONE).
- `out_valid` backpressure: DONE holds indefinitely with outputs stable.
- `in_ready` and `out_valid` are registered-state decodes with no combinational path from `in_valid` or `out_ready`.
- `out_crc`/`out_err` outside DONE: hold the last result (0 after reset).

## Configuration
- Macro: `CRC_N_CHECK_EN`.
- Defined: check mode is implemented as in Operation; `in_mode`, `in_crc` and the holding registers are live.
- Not defined:
  - Ports remain present.
  - `in_mode` and `in_crc` are ignored; no holding registers are synthesized.
  - `out_err` is constant 0.
  - Generate behaviour and timing are unchanged.

## Test plan
- Reset then idle, DW=8, BW=3, POLY=3'b011 → `in_ready`=1, `out_valid`=0, `out_crc`=3'b000, `out_err`=0, `busy`=0.
- Generate `in_data`=8'hD3, `out_ready`=1 → `out_valid` exactly 8 cycles after accept, `out_crc`=3'b011; next accept possible 10 cycles after the first.
- Generate 8'h80 then 8'h00 back-to-back → results 3'b011 then 3'b000. `in_valid` held high during SHIFT causes no extra accept.
- Backpressure: 8'hD3 with `out_ready`=0 for 5 cycles in DONE → `out_valid`/`out_crc`=3'b011 stable; `in_ready`=0 throughout; returns to IDLE the cycle after `out_ready`=1.
- Check mode (`CRC_N_CHECK_EN` defined): 8'hD3 with `in_crc`=3'b011 → `out_err`=0; with `in_crc`=3'b010 → `out_err`=1. Macro undefined, same stimulus → `out_err`=0 in both cases.
- Reset mid-operation: assert `rst` at SHIFT cycle 4 of 8'hD3 → next cycle all outputs at reset values; a new 8'h80 request then yields 3'b011 with no residue.
